// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and fetch controller for a 1-cycle-latency instruction memory
// Presents one word per cycle to decode, holds the read address during stalls, redirects on branch, faults out of range.
module fetch_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter int                MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              running,
  output logic              fault,
  output logic [31:0]       inst_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_FAULT} state_t;

  localparam logic [ADDR_W-1:0] DEPTH    = ADDR_W'(MEM_DEPTH);
  localparam logic              RESET_OK = (RESET_PC < DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] f_pc_q, f_pc_d;
  logic              f_valid_q, f_valid_d;
  logic [31:0]       cnt_q, cnt_d;

  logic is_run, is_stopped, adv, accept, tgt_ok, pc_ok;

  assign is_run     = (state_q == S_RUN);
  assign is_stopped = (state_q == S_IDLE) || (state_q == S_HALTED);
  assign adv        = is_run && (!f_valid_q || inst_ready);
  assign accept     = is_run && f_valid_q && inst_ready;
  assign tgt_ok     = (branch_target < DEPTH);
  assign pc_ok      = (pc_q < DEPTH);

  assign inst_out   = imem_inst;
  assign pc_out     = f_pc_q;
  assign inst_count = cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      f_pc_q    <= RESET_PC;
      f_valid_q <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    cnt_d     = cnt_q;
    // The word on the bus counts whenever it is taken, whatever else happens this cycle.
    if (accept && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          cnt_d = 32'd0;
          if (RESET_OK) begin
            state_d   = S_RUN;
            f_pc_d    = RESET_PC;
            f_valid_d = 1'b1;
            pc_d      = RESET_PC + 1'b1;
          end else begin
            state_d   = S_FAULT;
            f_valid_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d   = S_HALTED;
          f_valid_d = 1'b0;
        end else if (branch_taken) begin
          if (tgt_ok) begin
            f_pc_d    = branch_target;
            f_valid_d = 1'b1;
            pc_d      = branch_target + 1'b1;
          end else begin
            state_d   = S_FAULT;
            f_valid_d = 1'b0;
          end
        end else if (adv) begin
          if (pc_ok) begin
            f_pc_d    = pc_q;
            f_valid_d = 1'b1;
            pc_d      = pc_q + 1'b1;
          end else begin
            state_d   = S_FAULT;
            f_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = S_FAULT;
        f_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    running    = is_run;
    fault      = (state_q == S_FAULT);
    inst_valid = f_valid_q && is_run;
    // Falling back to f_pc re-reads the presented word, keeping imem_inst stable during stalls.
    imem_addr  = f_pc_q;
    if (is_stopped && start && RESET_OK) begin
      imem_addr = RESET_PC;
    end else if (is_run && branch_taken) begin
      if (tgt_ok) imem_addr = branch_target;
    end else if (adv && pc_ok) begin
      imem_addr = pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer against a fetch-stream model
module tb_fetch_sequencer;

  localparam int DEPTH = 128;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2, M_FAULT = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, halt = 1'b0, branch_taken = 1'b0, inst_ready = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] imem_addr, imem_inst, inst_out, pc_out, inst_count;
  logic        inst_valid, running, fault;

  logic [31:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the stream of presented addresses; the next sequential word is always shown+1.
  int          m_mode;
  logic [31:0] m_shown;
  logic [31:0] m_count;

  fetch_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_inst(imem_inst), .inst_out(inst_out),
    .pc_out(pc_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .running(running), .fault(fault), .inst_count(inst_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) imem_inst <= mem[imem_addr[6:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_shown = 32'd0;
    m_count = 32'd0;
  endtask

  task automatic model_step();
    if (m_mode == M_RUN && inst_ready && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    case (m_mode)
      M_IDLE, M_HALTED: if (start) begin
        m_count = 0;
        m_shown = 0;
        m_mode  = M_RUN;
      end
      M_RUN: begin
        if (halt) m_mode = M_HALTED;
        else if (branch_taken) begin
          if (branch_target < DEPTH) m_shown = branch_target;
          else m_mode = M_FAULT;
        end else if (inst_ready) begin
          if (m_shown + 1 < DEPTH) m_shown = m_shown + 1;
          else m_mode = M_FAULT;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check("inst_valid", inst_valid, m_mode == M_RUN);
    check("running", running, m_mode == M_RUN);
    check("fault", fault, m_mode == M_FAULT);
    check("inst_count", inst_count, m_count);
    if (m_mode == M_RUN) begin
      check("pc_out", pc_out, m_shown);
      check("inst_out", inst_out, mem[m_shown[6:0]]);
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    if (m_mode == M_RUN && !halt && !branch_taken && !inst_ready) begin
      #1 check("stall_addr", imem_addr, m_shown);
    end
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", inst_valid, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_count", inst_count, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; branch_taken = 0; inst_ready = 0; branch_target = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h0080_2820;
    mem[1] = 32'h0025_2820;
    model_reset();
    @(negedge clock);
    do_reset();

    // First fetch and streaming.
    start = 1; cycle(); start = 0;
    check("first_pc", pc_out, 32'd0);
    check("first_inst", inst_out, 32'h0080_2820);
    inst_ready = 1; cycle();
    check("second_inst", inst_out, 32'h0025_2820);
    cycle();
    check("third_pc", pc_out, 32'd2);

    // Stall three cycles on word 2.
    inst_ready = 0;
    repeat (3) cycle();
    check("stall_count", inst_count, 32'd2);
    inst_ready = 1; cycle();
    check("release_pc", pc_out, 32'd3);

    // Redirect from word 10 to word 2.
    repeat (7) cycle();
    check("at_ten", pc_out, 32'd10);
    branch_taken = 1; branch_target = 2; cycle(); branch_taken = 0;
    check("redirect_pc", pc_out, 32'd2);
    check("redirect_count", inst_count, 32'd11);

    // Halt beats branch; restart clears the count.
    halt = 1; branch_taken = 1; branch_target = 50; cycle();
    halt = 0; branch_taken = 0;
    check("halted_running", running, 1'b0);
    start = 1; cycle(); start = 0;
    check("restart_pc", pc_out, 32'd0);
    check("restart_count", inst_count, 32'd0);

    // Out-of-range branch faults and sticks.
    branch_taken = 1; branch_target = 200; cycle(); branch_taken = 0;
    check("branch_fault", fault, 1'b1);
    start = 1; repeat (3) cycle(); start = 0;
    check("fault_sticky", fault, 1'b1);

    // Sequential overrun past the last word.
    do_reset();
    start = 1; cycle(); start = 0;
    inst_ready = 1; branch_taken = 1; branch_target = 120; cycle(); branch_taken = 0;
    repeat (7) cycle();
    check("last_word", pc_out, 32'd127);
    cycle();
    check("overrun_fault", fault, 1'b1);
    repeat (2) cycle();

    // Asynchronous reset between clock edges.
    do_reset();
    start = 1; cycle(); start = 0;
    inst_ready = 1; repeat (5) cycle();
    #2 reset_n = 1'b0;
    #1;
    check("async_valid", inst_valid, 1'b0);
    check("async_running", running, 1'b0);
    check("async_count", inst_count, 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      idle_inputs();
      if ((m_mode == M_FAULT && $urandom_range(0, 7) == 0) || $urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        start        = ($urandom_range(0, 7) == 0);
        halt         = ($urandom_range(0, 15) == 0);
        branch_taken = ($urandom_range(0, 9) == 0);
        inst_ready   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 11) == 0) branch_target = $urandom_range(128, 300);
        else branch_target = $urandom_range(0, 127);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch controller that sequences the word-addressed instruction memory (InstMem: synchronous read, one-cycle latency, Mem[address[6:0]], 128 words).
- Issues addresses and tracks the in-flight word. Presents instructions to decode with a valid/ready handshake.
- Applies branch redirects and halt requests, and faults on out-of-range addresses.
- Sits between InstMem and the decode/execute stage of the single-cycle CSE BUBBLE core.

Parameters:
- ADDR_W, 32, width of PC and imem address.
- MEM_DEPTH, 128, number of valid instruction words; legal addresses are 0..MEM_DEPTH-1.
- RESET_PC, 0, first address fetched after start.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching from RESET_PC; honoured in IDLE and HALTED only.
- halt  in  1  stop fetching; honoured in RUN.
- branch_taken  in  1  redirect fetch to branch_target.
- branch_target  in  ADDR_W  word address of redirect.
- imem_addr  out  ADDR_W  address driven to InstMem.
- imem_inst  in  32  InstMem read data; corresponds to the address issued the previous cycle.
- inst_out  out  32  instruction to decode (equals imem_inst).
- pc_out  out  ADDR_W  address of inst_out.
- inst_valid  out  1  inst_out/pc_out valid.
- inst_ready  in  1  decode accepts inst_out this cycle.
- running  out  1  state == RUN.
- fault  out  1  state == FAULT.
- inst_count  out  32  count of accepted instructions.

Behaviour:
- Registers:
  - pc: next address to issue.
  - f_pc: address in flight/presented.
  - f_valid: in-flight word is live.
  - state: IDLE, RUN, HALTED, FAULT.
- Reset (async, reset_n=0) values:
  - state=IDLE; pc=RESET_PC; f_pc=RESET_PC; f_valid=0; inst_count=0.
  - Outputs follow: inst_valid=0, running=0, fault=0.
- Outputs:
  - inst_valid = f_valid & (state==RUN).
  - inst_out = imem_inst.
  - pc_out = f_pc.
- Handshake:
  - A word is accepted when inst_valid & inst_ready.
  - adv = (state==RUN) & (!f_valid | inst_ready).
- Address mux, combinational:
  - IDLE/HALTED with start: RESET_PC.
  - RUN with branch_taken: branch_target.
  - RUN with adv: pc.
  - Otherwise: f_pc. Re-reading the same word keeps imem_inst stable while decode stalls.
- IDLE / HALTED:
  - On start: state->RUN, f_pc<=RESET_PC, f_valid<=1, pc<=RESET_PC+1, inst_count<=0.
  - Other inputs are ignored.
- RUN, priority halt > branch > adv:
  - halt: state->HALTED, f_valid<=0. Branch is ignored. A word accepted in the same cycle still counts.
  - branch_taken, any inst_ready: f_pc<=branch_target, f_valid<=1, pc<=branch_target+1. The word presented this cycle counts only if inst_ready. The next valid word is Mem[branch_target] one cycle later, so there is no stale word after a redirect.
  - adv: f_pc<=pc, f_valid<=1, pc<=pc+1.
  - Otherwise: hold all state.
- Range check:
  - Applies to any address about to be issued (RESET_PC, branch_target, pc).
  - If that address >= MEM_DEPTH: do not issue, f_valid<=0, state->FAULT.
  - Sequential overrun: after Mem[MEM_DEPTH-1] is accepted with pc==MEM_DEPTH, the sequencer faults. No wrap-around or aliasing.
- FAULT:
  - Sticky; cleared only by reset.
  - inst_valid=0, imem_addr=f_pc.
- inst_count:
  - +1 per accepted word, saturating at 32'hFFFFFFFF.
  - Cleared on start.
- Latency: start to first inst_valid = 1 cycle; redirect to target word valid = 1 cycle; sustained throughput 1 word/cycle with inst_ready held high.
- Reset asserted mid-operation: immediate return to the reset values, independent of clock.

Test Plan:
- Reset then start, with Mem[0]=0x00802820, Mem[1]=0x00252820 and inst_ready=1:
  - Cycle+1: inst_valid=1, pc_out=0, inst_out=0x00802820.
  - Cycle+2: pc_out=1, inst_out=0x00252820.
  - inst_count increments each cycle.
- Stall: inst_ready=0 for 3 cycles while pc_out=2 → imem_addr=2 and inst_out=Mem[2] held all 3 cycles, inst_count unchanged. On release, pc_out=3 the next cycle.
- Redirect: branch_taken=1 with branch_target=2 while pc_out=10 and inst_ready=1 → next cycle pc_out=2, inst_out=Mem[2]. Word 11 never presented. Count +1 for word 10.
- Halt and branch asserted together → state HALTED, running=0, inst_valid=0 next cycle, branch ignored. Subsequent start resumes at pc_out=0 with inst_count=0.
- Faults:
  - branch_target=200 → fault=1, inst_valid=0 next cycle.
  - Sequential run past address 127 → fault=1 after word 127 is accepted.
  - In both cases fault stays set until reset_n=0.
- Async reset: assert reset_n=0 mid-cycle during RUN → inst_valid, running and inst_count drop to 0 immediately, without waiting for a clock edge.
